// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-port (CPU / I/O) round-robin arbiter for a single-cycle shared memory
// CPU lock pins the grant for read-modify-write; MAX_HOLD bounds back-to-back acks while the other side waits.
module mem_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cpu_req,
  input  logic         cpu_we,
  input  logic         cpu_lock,
  input  logic [15:31] cpu_addr,
  input  logic [0:31]  cpu_wdata,
  output logic         cpu_ack,
  output logic [0:31]  cpu_rdata,
  input  logic         io_req,
  input  logic         io_we,
  input  logic [15:31] io_addr,
  input  logic [0:31]  io_wdata,
  output logic         io_ack,
  output logic [0:31]  io_rdata,
  output logic [15:31] mem_addr,
  output logic         mem_we,
  output logic [0:31]  mem_wdata,
  input  logic [0:31]  mem_rdata,
  output logic [1:0]   owner
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GNT_CPU = 2'b01,
    GNT_IO  = 2'b10
  } state_t;

  localparam logic       LAST_CPU   = 1'b0;
  localparam logic       LAST_IO    = 1'b1;
  localparam logic [4:0] HOLD_LIMIT = 5'(MAX_HOLD);

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       last_owner, last_owner_nxt;
  logic [3:0] hold_inc;
  logic       hold_done;

  assign hold_inc  = (hold_cnt == 4'd15) ? hold_cnt : hold_cnt + 4'd1;
  assign hold_done = ({1'b0, hold_cnt} + 5'd1) >= HOLD_LIMIT;
  assign owner     = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      last_owner <= LAST_IO;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_owner_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    hold_nxt       = hold_cnt;
    last_owner_nxt = last_owner;
    cpu_ack        = 1'b0;
    io_ack         = 1'b0;
    cpu_rdata      = '0;
    io_rdata       = '0;
    mem_addr       = '0;
    mem_we         = 1'b0;
    mem_wdata      = '0;

    case (state)
      IDLE: begin
        // On a tie the side not served last wins
        if (cpu_req && (!io_req || last_owner == LAST_IO)) state_nxt = GNT_CPU;
        else if (io_req)                                    state_nxt = GNT_IO;
      end
      GNT_CPU: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        cpu_ack   = cpu_req;
        mem_we    = cpu_req & cpu_we;
        if (cpu_req) begin
          cpu_rdata = mem_rdata;
          hold_nxt  = hold_inc;
          if (io_req && hold_done && !cpu_lock) state_nxt = GNT_IO;
        end else begin
          state_nxt = io_req ? GNT_IO : IDLE;
        end
        if (state_nxt != GNT_CPU) last_owner_nxt = LAST_CPU;
      end
      GNT_IO: begin
        mem_addr  = io_addr;
        mem_wdata = io_wdata;
        io_ack    = io_req;
        mem_we    = io_req & io_we;
        if (io_req) begin
          io_rdata = mem_rdata;
          hold_nxt = hold_inc;
          if (cpu_req && hold_done) state_nxt = GNT_CPU;
        end else begin
          state_nxt = cpu_req ? GNT_CPU : IDLE;
        end
        if (state_nxt != GNT_IO) last_owner_nxt = LAST_IO;
      end
      default: state_nxt = IDLE;
    endcase

    if (state_nxt != state) hold_nxt = '0;
  end

endmodule
